// File: rtl/spi_adc_scanner_if.sv
// Signal bundle between spi_adc_scanner and its surroundings:
// scan control, the shared SPI lines and the tagged result port.
interface spi_adc_scanner_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 12,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic              enable;
    logic [N_CH-1:0]   ch_mask;
    logic              MISO;
    logic              SCK;
    logic              MOSI;
    logic [N_CH-1:0]   CS;
    logic [DATA_W-1:0] o_DATA;
    logic [CH_W-1:0]   o_CH;
    logic              DATA_VALID;
    logic              busy;

    modport slave (
        input  enable, ch_mask, MISO,
        output SCK, MOSI, CS, o_DATA, o_CH, DATA_VALID, busy
    );

    modport master (
        output enable, ch_mask, MISO,
        input  SCK, MOSI, CS, o_DATA, o_CH, DATA_VALID, busy
    );
endinterface

// File: rtl/spi_adc_scanner.sv
// Round-robin reader for N_CH SPI ADCs sharing SCK/MISO, one active-low CS each.
// Define SPI_SCAN_AVG_EN to report the mean of 2**AVG_LOG2 samples per channel.
module spi_adc_scanner #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 12,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 3,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYC    = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    spi_adc_scanner_if.slave bus
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(LEAD_BITS);
    localparam logic [BIT_W-1:0] DATA_END   = BIT_W'(LEAD_BITS + DATA_W);
    localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(GAP_CYC);

    if (N_CH < 1 || N_CH > 16 || CLK_DIV < 1 || GAP_CYC < 1 || AVG_LOG2 < 0 ||
        LEAD_BITS + DATA_W > FRAME_BITS) begin : g_bad_params
        $error("spi_adc_scanner: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_next;
    logic [GAP_W-1:0]  gap;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   next_ch;
    logic              found;
    logic [DATA_W-1:0] shreg;
    logic              sck;
    logic [N_CH-1:0]   cs;
    logic [DATA_W-1:0] o_data;
    logic [CH_W-1:0]   o_ch;
    logic              data_valid;
    logic              busy;

`ifdef SPI_SCAN_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc [N_CH];
    logic [CNT_W-1:0] cnt [N_CH];
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum = acc[ptr] + ACC_W'(shreg);
`endif

    assign bit_next = bit_idx + 1'b1;

    // Bits outside the data window (lead-in and trailing bits) are discarded.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                   input logic [BIT_W-1:0]  b,
                                                   input logic              din);
        if (b >= DATA_FIRST && b < DATA_END)
            return (cur << 1) | DATA_W'(din);
        return cur;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_ch = ptr;
        found   = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!found && bus.ch_mask[CH_W'((int'(ptr) + i) % N_CH)]) begin
                next_ch = CH_W'((int'(ptr) + i) % N_CH);
                found   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_idx    <= '0;
            gap        <= '0;
            ptr        <= CH_W'(N_CH - 1);
            shreg      <= '0;
            sck        <= 1'b0;
            cs         <= '1;
            o_data     <= '0;
            o_ch       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef SPI_SCAN_AVG_EN
            // NOTE: the accumulators are per-channel flops, not RAM, so reset clears them outright.
            for (int i = 0; i < N_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
`endif
        end else begin
            data_valid <= 1'b0;
            if (gap != GAP_MAX)
                gap <= gap + 1'b1;

            case (state)
                IDLE: begin
                    if (bus.enable && found && gap >= GAP_MAX) begin
                        ptr     <= next_ch;
                        cs      <= ~(N_CH'(1) << next_ch);
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_idx <= '0;
                        sck     <= 1'b1;
                        shreg   <= shift_in(shreg, '0, bus.MISO);
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (sck) begin
                            sck <= 1'b0;
                        end else if (bit_idx == BIT_LAST) begin
                            // Frame complete: the DONE outputs are loaded on the edge entering DONE.
                            cs    <= '1;
                            busy  <= 1'b0;
                            gap   <= '0;
                            state <= DONE;
`ifdef SPI_SCAN_AVG_EN
                            if (cnt[ptr] == CNT_LAST) begin
                                o_data     <= DATA_W'(acc_sum >> AVG_LOG2);
                                o_ch       <= ptr;
                                data_valid <= 1'b1;
                                acc[ptr]   <= '0;
                                cnt[ptr]   <= '0;
                            end else begin
                                acc[ptr] <= acc_sum;
                                cnt[ptr] <= cnt[ptr] + 1'b1;
                            end
`else
                            o_data     <= shreg;
                            o_ch       <= ptr;
                            data_valid <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_next;
                            sck     <= 1'b1;
                            shreg   <= shift_in(shreg, bit_next, bus.MISO);
                        end
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.SCK        = sck;
    assign bus.MOSI       = 1'b0;  // the ADCs are read-only
    assign bus.CS         = cs;
    assign bus.o_DATA     = o_data;
    assign bus.o_CH       = o_ch;
    assign bus.DATA_VALID = data_valid;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_spi_adc_scanner.sv
// Self-checking bench for spi_adc_scanner: ADC line model, bus monitor, vector table,
// directed corner sequences and a randomized run against a channel-rotation model.
module tb_spi_adc_scanner;
    localparam int N_CH       = 4;
    localparam int DATA_W     = 12;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS  = 3;
    localparam int CLK_DIV    = 2;
    localparam int GAP_CYC    = 4;
    localparam int AVG_LOG2   = 2;
    localparam int CH_W       = 2;
    localparam int CS_LOW_CYC = CLK_DIV + 2 * CLK_DIV * FRAME_BITS;
    localparam int DV_BOUND   = 400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_adc_scanner_if #(.N_CH(N_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

    spi_adc_scanner #(
        .N_CH(N_CH), .DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS), .LEAD_BITS(LEAD_BITS),
        .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .CLK100MHZ(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ADC frame word per channel, shifted out MSB first.
    logic [FRAME_BITS-1:0] word [N_CH];

    int   cyc = 0, rises = 0, cur_len = 0, last_len = 0, last_rises = 0;
    int   high_len = 0, last_gap = 0, frames = 0, dv_cnt = 0, busy_cyc = 0, sck_hi_cyc = 0;
    int   multi_lo = 0, mosi_bad = 0, period_bad = 0, last_rise_t = -1, act_ch = 0;
    int   low_cyc [N_CH] = '{default: 0};
    logic in_frame = 1'b0, sck_q = 1'b0;

    // Bus monitor and ADC model; MISO changes only on the falling clock edge.
    always @(negedge clk) begin
        logic [N_CH-1:0] lo;
        lo = ~bus.CS;
        cyc++;
        if ($countones(lo) > 1) multi_lo++;
        if (bus.MOSI !== 1'b0) mosi_bad++;
        if (bus.SCK) sck_hi_cyc++;
        if (bus.busy) busy_cyc++;
        if (bus.DATA_VALID) dv_cnt++;
        for (int i = 0; i < N_CH; i++) if (lo[i]) low_cyc[i]++;
        if (lo != '0) begin
            if (!in_frame) begin
                in_frame    = 1'b1;
                last_gap    = high_len;
                high_len    = 0;
                cur_len     = 0;
                rises       = 0;
                last_rise_t = -1;
                for (int i = N_CH - 1; i >= 0; i--) if (lo[i]) act_ch = i;
            end
            cur_len++;
        end else begin
            if (in_frame) begin
                in_frame   = 1'b0;
                last_len   = cur_len;
                last_rises = rises;
                frames++;
            end
            high_len++;
        end
        if (bus.SCK && !sck_q) begin
            if (last_rise_t >= 0 && cyc - last_rise_t != 2 * CLK_DIV) period_bad++;
            last_rise_t = cyc;
            rises++;
        end
        sck_q = bus.SCK;
        if (in_frame && rises < FRAME_BITS) bus.MISO = word[act_ch][FRAME_BITS-1-rises];
        else                                bus.MISO = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_dv(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.DATA_VALID && n < DV_BOUND);
        check({name, "_dv_seen"}, 32'(bus.DATA_VALID), 32'd1);
    endtask

    function automatic logic [FRAME_BITS-1:0] enc(input logic [DATA_W-1:0] v,
                                                  input logic [LEAD_BITS-1:0] lead,
                                                  input logic tail);
        return {lead, v, tail};
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [FRAME_BITS-1:0] w);
        return DATA_W'(w >> (FRAME_BITS - LEAD_BITS - DATA_W));
    endfunction

    // Spec rule: lowest enabled index above the previous channel, wrapping to 0.
    function automatic int next_enabled(input int prev, input logic [N_CH-1:0] m);
        for (int k = 1; k <= N_CH; k++)
            if (m[(prev + k) % N_CH]) return (prev + k) % N_CH;
        return -1;
    endfunction

    task automatic reset_checks();
        check("rst_cs",    32'(bus.CS), 32'hF);
        check("rst_sck",   32'(bus.SCK), 32'd0);
        check("rst_mosi",  32'(bus.MOSI), 32'd0);
        check("rst_data",  32'(bus.o_DATA), 32'd0);
        check("rst_ch",    32'(bus.o_CH), 32'd0);
        check("rst_valid", 32'(bus.DATA_VALID), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
    endtask

    task automatic mask_zero_test(input logic [DATA_W-1:0] hold_data, input logic [CH_W-1:0] hold_ch);
        int dv0, f0, b0, s0;
        bus.ch_mask = '0;
        bus.enable  = 1'b1;
        tick(100);
        dv0 = dv_cnt; f0 = frames; b0 = busy_cyc; s0 = sck_hi_cyc;
        tick(500);
        check("m0_no_valid", 32'(dv_cnt), 32'(dv0));
        check("m0_no_frame", 32'(frames), 32'(f0));
        check("m0_no_busy",  32'(busy_cyc), 32'(b0));
        check("m0_sck_low",  32'(sck_hi_cyc), 32'(s0));
        check("m0_cs_high",  32'(bus.CS), 32'hF);
        check("m0_hold_data", 32'(bus.o_DATA), 32'(hold_data));
        check("m0_hold_ch",   32'(bus.o_CH), 32'(hold_ch));
    endtask

    typedef struct {
        logic [N_CH-1:0]   mask;
        logic [CH_W-1:0]   exp_ch;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{4'b1011, 2'd0, 12'h111};
        vecs[1]  = '{4'b1011, 2'd1, 12'h222};
        vecs[2]  = '{4'b1011, 2'd3, 12'h444};
        vecs[3]  = '{4'b1011, 2'd0, 12'h111};
        vecs[4]  = '{4'b1011, 2'd1, 12'h222};
        vecs[5]  = '{4'b1011, 2'd3, 12'h444};
        vecs[6]  = '{4'b0100, 2'd2, 12'h333};
        vecs[7]  = '{4'b0100, 2'd2, 12'h333};
        vecs[8]  = '{4'b1001, 2'd3, 12'h444};
        vecs[9]  = '{4'b1001, 2'd0, 12'h111};
        vecs[10] = '{4'b0110, 2'd1, 12'h222};
        vecs[11] = '{4'b1111, 2'd2, 12'h333};

        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.ch_mask = '0;
        for (int c = 0; c < N_CH; c++) word[c] = '0;
        tick(3);
        reset_checks();

`ifdef SPI_SCAN_AVG_EN
        begin
            logic [DATA_W-1:0] vals [4];
            int dv0, f0, n;
            vals = '{12'h100, 12'h101, 12'h102, 12'h104};
            bus.ch_mask = 4'b0001;
            bus.enable  = 1'b1;
            word[0]     = enc(vals[0], 3'b000, 1'b0);
            dv0         = dv_cnt;
            tick();
            reset = 1'b0;
            for (int k = 0; k < 4; k++) begin
                word[0] = enc(vals[k], 3'($urandom), 1'($urandom));
                f0 = frames;
                n  = 0;
                while (frames == f0 && n < DV_BOUND) begin
                    tick();
                    n++;
                end
                check($sformatf("avg_frame%0d_done", k), 32'(frames), 32'(f0 + 1));
                if (k < 3) check($sformatf("avg_nopulse%0d", k), 32'(dv_cnt), 32'(dv0));
            end
            check("avg_one_pulse", 32'(dv_cnt), 32'(dv0 + 1));
            check("avg_data", 32'(bus.o_DATA), 32'h101);
            check("avg_ch",   32'(bus.o_CH), 32'd0);
            mask_zero_test(12'h101, 2'd0);
        end
`else
        // Single channel: waveform, frame timing and back-to-back gap.
        begin
            int n;
            bus.ch_mask = 4'b0001;
            bus.enable  = 1'b1;
            word[0]     = 16'h14B8;
            reset       = 1'b0;
            wait_dv("t1");
            check("t1_data",     32'(bus.o_DATA), 32'hA5C);
            check("t1_ch",       32'(bus.o_CH), 32'd0);
            check("t1_cs_low",   32'(last_len), 32'(CS_LOW_CYC));
            check("t1_rises",    32'(last_rises), 32'(FRAME_BITS));
            check("t1_sck_per",  32'(period_bad), 32'd0);
            check("t1_mosi",     32'(mosi_bad), 32'd0);
            tick();
            check("t1_pulse_1cyc", 32'(bus.DATA_VALID), 32'd0);
            n = 0;
            while (!in_frame && n < 50) begin
                tick();
                n++;
            end
            check("t1_refire_ch0", 32'(bus.CS), 32'hE);
            check("t1_gap",        32'(last_gap), 32'(GAP_CYC + 1));
        end

        // Vector table: rotation order and data extraction with junk lead/tail bits.
        begin
            int ch2_low0;
            reset = 1'b1;
            tick(2);
            word[0] = enc(12'h111, 3'($urandom), 1'($urandom));
            word[1] = enc(12'h222, 3'($urandom), 1'($urandom));
            word[2] = enc(12'h333, 3'($urandom), 1'($urandom));
            word[3] = enc(12'h444, 3'($urandom), 1'($urandom));
            bus.ch_mask = vecs[0].mask;
            ch2_low0 = low_cyc[2];
            reset = 1'b0;
            for (int i = 0; i < 12; i++) begin
                bus.ch_mask = vecs[i].mask;
                wait_dv($sformatf("vec%0d", i));
                check($sformatf("vec%0d_ch", i),   32'(bus.o_CH), 32'(vecs[i].exp_ch));
                check($sformatf("vec%0d_data", i), 32'(bus.o_DATA), 32'(vecs[i].exp_data));
                if (i == 5) check("vec_cs2_never_low", 32'(low_cyc[2]), 32'(ch2_low0));
            end
        end

        // Mask and enable change in the middle of channel 1's frame.
        begin
            int n, f0;
            bus.ch_mask = 4'b1011;
            n = 0;
            while (!(in_frame && act_ch == 1 && rises == 8) && n < 1000) begin
                tick();
                n++;
            end
            check("mid_reached_bit7", 32'(in_frame && act_ch == 1 && rises == 8), 32'd1);
            bus.ch_mask = 4'b0100;
            bus.enable  = 1'b0;
            wait_dv("mid");
            check("mid_ch",   32'(bus.o_CH), 32'd1);
            check("mid_data", 32'(bus.o_DATA), 32'h222);
            f0 = frames;
            tick(60);
            check("mid_hold_off", 32'(frames), 32'(f0));
            check("mid_cs_high",  32'(bus.CS), 32'hF);
            bus.enable = 1'b1;
            wait_dv("mid_resume");
            check("mid_next_ch",   32'(bus.o_CH), 32'd2);
            check("mid_next_data", 32'(bus.o_DATA), 32'h333);
        end

        // Reset on bit 10 of a frame aborts it.
        begin
            int n, dv0;
            bus.ch_mask = 4'b0001;
            n = 0;
            while (!(in_frame && act_ch == 0 && rises == 11) && n < 1000) begin
                tick();
                n++;
            end
            check("rstmid_reached_bit10", 32'(in_frame && act_ch == 0 && rises == 11), 32'd1);
            dv0   = dv_cnt;
            reset = 1'b1;
            tick();
            reset_checks();
            check("rstmid_no_valid", 32'(dv_cnt), 32'(dv0));
            bus.ch_mask = 4'b0110;
            tick(2);
            reset = 1'b0;
            wait_dv("rstmid_first");
            check("rstmid_first_ch",   32'(bus.o_CH), 32'd1);
            check("rstmid_first_data", 32'(bus.o_DATA), 32'h222);
        end

        mask_zero_test(12'h222, 2'd1);

        // Randomized run against the rotation/extraction reference.
        begin
            int model_ptr, exp_ch;
            logic [N_CH-1:0]   m;
            logic [DATA_W-1:0] exp_d;
            reset = 1'b1;
            do m = N_CH'($urandom); while (m == '0);
            bus.ch_mask = m;
            bus.enable  = 1'b1;
            tick(2);
            reset     = 1'b0;
            model_ptr = N_CH - 1;
            for (int it = 0; it < 40; it++) begin
                for (int c = 0; c < N_CH; c++) word[c] = FRAME_BITS'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    do m = N_CH'($urandom); while (m == '0);
                    bus.ch_mask = m;
                end
                if ($urandom_range(0, 4) == 0) begin
                    bus.enable = 1'b0;
                    tick($urandom_range(1, 20));
                    bus.enable = 1'b1;
                end
                exp_ch = next_enabled(model_ptr, bus.ch_mask);
                exp_d  = extract(word[exp_ch]);
                wait_dv($sformatf("rnd%0d", it));
                check($sformatf("rnd%0d_ch", it),   32'(bus.o_CH), 32'(exp_ch));
                check($sformatf("rnd%0d_data", it), 32'(bus.o_DATA), 32'(exp_d));
                model_ptr = exp_ch;
            end
        end
`endif

        check("one_cs_low_max", 32'(multi_lo), 32'd0);
        check("mosi_always_0",  32'(mosi_bad), 32'd0);
        check("sck_period",     32'(period_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_adc_scanner.md
Name: spi_adc_scanner

Overview:
- Parametrised multi-channel SPI ADC front end; successor to the single-channel 12-bit SPI reader.
- Round-robins over N_CH serial ADCs: shared SCK/MISO, one active-low chip select per channel, per-channel enable mask.
- Emits each conversion as a one-cycle DATA_VALID pulse with channel tag, feeding LED/7-seg display logic.
- Runs directly on CLK100MHZ with an internal SCK divider; no separate prescaled clock.

Parameters:
- N_CH, 4: number of ADC channels (1..16).
- DATA_W, 12: ADC result width.
- FRAME_BITS, 16: SCK cycles per conversion frame.
- LEAD_BITS, 3: leading bits before the data MSB. LEAD_BITS+DATA_W <= FRAME_BITS, MSB first.
- CLK_DIV, 2: SCK half-period in CLK100MHZ cycles (>=1).
- GAP_CYC, 4: minimum CS-high cycles between frames (>=1).
- AVG_LOG2, 2: log2 of samples averaged. Used only with SPI_SCAN_AVG_EN.

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scanning allowed while high.
- ch_mask  in  N_CH  bit i=1 includes channel i in the scan.
- MISO  in  1  shared serial data from ADCs.
- SCK  out  1  serial clock; idles low.
- MOSI  out  1  tied to 0 (ADCs are read-only).
- CS  out  N_CH  active-low chip selects; at most one low at a time.
- o_DATA  out  DATA_W  last conversion result.
- o_CH  out  CH_W  channel of o_DATA; CH_W = max(1, clog2(N_CH)).
- DATA_VALID  out  1  one-cycle pulse: o_DATA/o_CH are new.
- busy  out  1  high while any CS is low.

Behaviour:
- All outputs are registered.
- Reset: CS all 1, SCK=0, MOSI=0, o_DATA=0, o_CH=0, DATA_VALID=0, busy=0, FSM=IDLE, gap counter=0, channel pointer=N_CH-1 (so the first pick is the lowest enabled index). A mid-frame reset aborts the frame: CS rises the next cycle, no DATA_VALID.
- FSM states:
  - IDLE: wait until gap counter >= GAP_CYC, enable=1 and ch_mask!=0. Then select the next enabled channel: lowest set mask index above the pointer, wrapping to 0. Drive its CS low, set busy, go to SETUP. Stays in IDLE if mask=0 or enable=0.
  - SETUP: SCK low for CLK_DIV cycles, then go to SHIFT.
  - SHIFT, per bit:
    - Drive SCK 0->1 and sample MISO on that same clock edge.
    - Hold SCK high CLK_DIV cycles, then low CLK_DIV cycles.
    - Sampled bits with index LEAD_BITS..LEAD_BITS+DATA_W-1 shift MSB-first into the data register; other bits are discarded.
    - After FRAME_BITS bits, and after the last low half, go to DONE.
  - DONE, one cycle:
    - CS all high, busy=0.
    - o_DATA/o_CH load; DATA_VALID=1 this cycle only.
    - Clear gap counter; go to IDLE.
- CS low duration is exactly CLK_DIV + 2*CLK_DIV*FRAME_BITS cycles.
- Frame-to-frame CS-high time is GAP_CYC+1 cycles when continuously enabled.
- ch_mask and enable are sampled only in IDLE. Mid-frame changes take effect at the next selection, and a started frame always completes.
- Single enabled channel: the same channel is rescanned every frame.
- o_DATA/o_CH hold their values between DATA_VALID pulses.

Optional Feature:
- Macro SPI_SCAN_AVG_EN.
- Defined:
  - Each channel has an accumulator (DATA_W+AVG_LOG2 bits, cleared on reset) and a sample counter.
  - On DONE the sample is added. After 2^AVG_LOG2 samples of that channel: o_DATA = accumulator >> AVG_LOG2 (truncating), o_CH = channel, DATA_VALID pulses, and the accumulator and counter clear.
  - Otherwise DONE produces no pulse.
  - Removing a channel from ch_mask retains its partial accumulation.
- Undefined: every frame produces DATA_VALID with the raw sample; AVG_LOG2 is ignored and no accumulators exist.

Test Plan:
- Defaults, ch_mask=4'b0001, enable=1, ADC model frame 000_1010_0101_1100_0 -> DATA_VALID with o_DATA=12'hA5C, o_CH=0; CS[0] low 66 cycles; SCK period 4 cycles; 16 rising edges; MOSI=0 throughout.
- ch_mask=4'b1011, per-channel values 0x111/0x222/-/0x444 -> o_CH sequence 0,1,3,0,1,3; CS[2] never low; never more than one CS low; 5 CS-high cycles between frames.
- Mid-frame: change ch_mask 4'b1011->4'b0100 and drop enable on bit 7 of channel 1's frame -> channel 1 frame completes with valid data; then CS stays high until enable returns; the next frame is channel 2.
- Reset asserted on bit 10 of a frame -> next cycle CS=all 1, SCK=0, no DATA_VALID, outputs at reset values; after release the first frame is on the lowest enabled channel.
- ch_mask=0, enable=1 for 500 cycles -> CS all high, SCK low, busy=0, no DATA_VALID.
- SPI_SCAN_AVG_EN, AVG_LOG2=2, channel 0 samples 0x100, 0x101, 0x102, 0x104 -> one DATA_VALID after the 4th frame, o_DATA=0x101 (0x407>>2); no pulse after frames 1-3.
